bpsk_demodulator: RTL

BPSK_DEMODULATOR -- requirements
Module: bpsk_demodulator

---
 rtl/bpsk_pkg.sv | 45 ++++
 rtl/bpsk_bit_correlator.sv | 67 ++++++
 rtl/bpsk_demodulator.sv | 119 +++++++++++
 3 files changed

// File: rtl/bpsk_pkg.sv
// bpsk_pkg: constants shared by the BPSK transmit and receive paths.
//   SPB        samples per bit (power of two)
//   WORD_W     decoded bits per output word
//   state_e    receiver FSM states
//   CARRIER    signed 16-bit sine table, one entry per sample of a bit
//   modulate() symbol mapping used by the transmitter (1 = +carrier, 0 = -carrier)
package bpsk_pkg;

  localparam int unsigned SPB       = 8;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned PROD_W    = 2 * SAMPLE_W;
  localparam int unsigned CAR_IDX_W = $clog2(SPB);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One full sine period, phase index 0 at the first sample of every bit.
  localparam logic signed [SAMPLE_W-1:0] CARRIER [SPB] = '{
    16'sd0,
    16'sd23170,
    16'sd32767,
    16'sd23170,
    16'sd0,
    -16'sd23170,
    -16'sd32767,
    -16'sd23170
  };

  // Carrier value at a given phase index.
  function automatic logic signed [SAMPLE_W-1:0] carrier_at(input logic [CAR_IDX_W-1:0] idx);
    return CARRIER[idx];
  endfunction

  // Transmit-side sample for one bit at one phase index.
  function automatic logic signed [SAMPLE_W-1:0] modulate(input logic b,
                                                          input logic [CAR_IDX_W-1:0] idx);
    logic signed [SAMPLE_W-1:0] c;
    c = CARRIER[idx];
    return b ? c : -c;
  endfunction

endpackage

// File: rtl/bpsk_bit_correlator.sv
// bpsk_bit_correlator: multiplies each accepted sample by the carrier, sums
// over one bit period and decides the bit from the sign of the sum.
//   clk, rst     clock and synchronous active-high reset
//   en           process this sample
//   start        this sample is phase 0 of a fresh bit (discard partial sum)
//   sample       signed received sample
//   bit_done_c   high in the cycle the SPB-th sample of a bit is processed
//   bit_c        decision for that bit (1 when sum > 0, else 0)
module bpsk_bit_correlator #(
  parameter int unsigned SPB = bpsk_pkg::SPB
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  input  logic signed [15:0]  sample,
  output logic                bit_done_c,
  output logic                bit_c
);
  import bpsk_pkg::*;

  localparam int unsigned PH_W  = $clog2(SPB);
  localparam int unsigned ACC_W = PROD_W + PH_W;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [PH_W-1:0]          phase_q, phase_d;

  logic signed [ACC_W-1:0]  acc_base_c;
  logic [PH_W-1:0]          phase_cur_c;
  logic signed [15:0]       car_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  sum_c;

  // MAC and bit-boundary detection; a start sample behaves as phase 0 on an empty sum.
  always_comb begin
    acc_d       = acc_q;
    phase_d     = phase_q;
    acc_base_c  = start ? '0 : acc_q;
    phase_cur_c = start ? '0 : phase_q;
    car_c       = carrier_at(CAR_IDX_W'(phase_cur_c));
    prod_c      = PROD_W'(sample) * PROD_W'(car_c);
    sum_c       = acc_base_c + ACC_W'(prod_c);
    bit_done_c  = en && (phase_cur_c == PH_W'(SPB - 1));
    // Strictly positive wins; zero (tie) decides 0.
    bit_c       = !sum_c[ACC_W-1] && (sum_c != '0);
    if (en) begin
      if (bit_done_c) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum_c;
        phase_d = phase_cur_c + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      phase_q <= '0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/bpsk_demodulator.sv
// bpsk_demodulator: coherent BPSK receiver producing bits and packed words.
//   clk, rst   clock and synchronous active-high reset
//   en         sample strobe; sof marks the first sample of a frame
//   sample     signed 16-bit received sample
//   bit_out    most recent decided bit, bit_valid pulses when it updates
//   data       last complete word (first bit in MSB), valid pulses when it updates
//   busy       high while receiving a frame
module bpsk_demodulator #(
  parameter int unsigned SPB    = bpsk_pkg::SPB,
  parameter int unsigned WORD_W = bpsk_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sof,
  input  logic [15:0]       sample,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  output logic              busy
);
  import bpsk_pkg::*;

  localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                bit_out_q, bit_out_d;
  logic                bit_valid_q, bit_valid_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic                start_c;
  logic                proc_c;
  logic                bit_done_c;
  logic                bit_c;
  logic [WORD_W-1:0]   shifted_c;

  // In IDLE only a sof sample is processed; in RUN every accepted sample is.
  assign start_c = en & sof;
  assign proc_c  = en & (sof | (state_q == ST_RUN));

  bpsk_bit_correlator #(
    .SPB (SPB)
  ) u_corr (
    .clk        (clk),
    .rst        (rst),
    .en         (proc_c),
    .start      (start_c),
    .sample     (sample),
    .bit_done_c (bit_done_c),
    .bit_c      (bit_c)
  );

  // Frame control, MSB-first word assembly and output pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    valid_d     = 1'b0;
    shifted_c   = WORD_W'({shreg_q, bit_c});

    if (start_c) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      shreg_d = '0;
    end

    if (bit_done_c) begin
      bit_out_d   = bit_c;
      bit_valid_d = 1'b1;
      shreg_d     = shifted_c;
      if (cnt_q == CNT_W'(WORD_W - 1)) begin
        data_d  = shifted_c;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule
